// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: reset/bubble
// defaults and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEF  = 64'h0;
  localparam int unsigned PC_STEP_DEF   = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory channel between the fetch unit (master) and the
// instruction memory (slave).
interface fetch_unit_if #(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
) ();

  // Request: a transfer happens on a rising edge where imem_req_valid and
  // imem_req_ready are both high; once valid is raised, imem_addr holds until
  // accepted (only a redirect may withdraw it). Response: imem_resp_valid is a
  // one-cycle pulse carrying imem_resp_data, with no back-pressure.
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [BUS_WIDTH-1:0]   imem_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time,
// buffers the returned word and feeds {pc, instr} into the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                     BUS_WIDTH   = 64,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0]   RESET_PC    = BUS_WIDTH'(RESET_PC_DEF),
  parameter int unsigned            PC_STEP     = PC_STEP_DEF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [BUS_WIDTH-1:0]   redirect_pc,
  fetch_unit_if.master           imem,
  output logic [BUS_WIDTH-1:0]   out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   out_valid,
  output fetch_state_e           dbg_state
);

  fetch_state_e           state_q, state_d;
  logic [BUS_WIDTH-1:0]   pc_q, pc_d;
  logic [BUS_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [BUS_WIDTH-1:0]   buf_pc_q, buf_pc_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;

  logic                   req_fire;
  logic                   resp;
  logic [BUS_WIDTH-1:0]   redirect_target;

  // A redirect in FETCH withdraws the request so no stale address is issued.
  assign imem.imem_req_valid = (state_q == ST_FETCH) && !redirect && !rst;
  assign imem.imem_addr      = pc_q;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
  assign resp                = imem.imem_resp_valid;
  assign redirect_target     = redirect_pc & ~BUS_WIDTH'(3);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    case (state_q)
      ST_FETCH: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + BUS_WIDTH'(PC_STEP);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          state_d = resp ? ST_FETCH : ST_DRAIN;
        end else if (resp) begin
          buf_instr_d = imem.imem_resp_data;
          buf_pc_d    = req_pc_q;
          state_d     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (redirect || !stall) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        if (resp) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Redirect outranks everything, including a stalled IF/ID.
    if (redirect) pc_d = redirect_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_pc_q    <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_instr = out_valid ? buf_instr_q : NOP_INSTR;
  assign out_pc    = buf_pc_q;
  assign dbg_state = state_q;

  // Responses are only legal while a request is outstanding.
  resp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (rst)
      !(imem.imem_resp_valid && (state_q == ST_FETCH || state_q == ST_FULL))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level
// model: expected fetch address stream plus a queue of deliverable {pc, instr}.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         redirect;
  logic [63:0]  redirect_pc;
  logic [63:0]  out_pc;
  logic [31:0]  out_instr;
  logic         out_valid;
  fetch_state_e dbg_state;

  fetch_unit_if #(.BUS_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_valid   (out_valid),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // stimulus settings for the next cycle
  logic        st_rst, st_stall, st_redirect, st_ready;
  logic [63:0] st_target;
  int          st_lat;
  logic [31:0] data_q[$];

  // reference model
  logic [63:0] exp_pc;
  logic [63:0] last_pc;
  logic [95:0] exp_q[$];
  logic        mem_busy, mem_stale;
  int          mem_lat;
  logic [63:0] mem_pc;
  logic [31:0] mem_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RST_PC;
    last_pc   = RST_PC;
    exp_q.delete();
    mem_busy  = 1'b0;
    mem_stale = 1'b0;
    mem_lat   = 0;
    mem_pc    = '0;
    mem_data  = '0;
  endtask

  task automatic do_cycle();
    logic        exp_rv;
    logic        hs;
    logic [95:0] item;
    rst                 = st_rst;
    stall               = st_stall;
    redirect            = st_redirect;
    redirect_pc         = st_target;
    bus.imem_req_ready  = st_ready;
    bus.imem_resp_valid = mem_busy && (mem_lat == 0);
    bus.imem_resp_data  = mem_data;
    #2;
    // a request is offered only when nothing is outstanding or buffered
    exp_rv = !st_rst && !st_redirect && !mem_busy && (exp_q.size() == 0);
    check("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", bus.imem_addr, exp_pc);
    hs = exp_rv && st_ready;
    if (st_rst) begin
      model_reset();
    end else begin
      if (exp_q.size() != 0 && (st_redirect || !st_stall)) begin
        item    = exp_q.pop_front();
        last_pc = item[95:32];
      end
      if (mem_busy && mem_lat == 0) begin
        if (!mem_stale && !st_redirect) exp_q.push_back({mem_pc, mem_data});
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_lat--;
      end
      if (st_redirect) begin
        exp_pc = st_target & ~64'h3;
        if (mem_busy) mem_stale = 1'b1;
      end
      if (hs) begin
        mem_busy  = 1'b1;
        mem_stale = 1'b0;
        mem_pc    = exp_pc;
        mem_lat   = (st_lat < 0) ? int'($urandom_range(0, 3)) : st_lat;
        mem_data  = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
        exp_pc    = exp_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0][95:32]);
      check("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
    end else begin
      check("bubble_instr", 64'(out_instr), 64'(NOP));
      check("bubble_pc", out_pc, last_pc);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!mem_busy && n < 30) begin do_cycle(); n++; end
    check("wait_busy_bound", 64'(mem_busy), 64'(1));
  endtask

  task automatic wait_full();
    int n = 0;
    while (exp_q.size() == 0 && n < 30) begin do_cycle(); n++; end
    check("wait_full_bound", 64'(exp_q.size() != 0), 64'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mem_busy || exp_q.size() != 0) && n < 30) begin do_cycle(); n++; end
    check("wait_idle_bound", 64'(mem_busy || exp_q.size() != 0), 64'(0));
  endtask

  initial begin
    model_reset();
    st_rst = 1'b1; st_stall = 1'b0; st_redirect = 1'b0; st_ready = 1'b1;
    st_target = '0; st_lat = 0;

    // reset, then two back-to-back fetches with a 1-cycle memory
    cyc(2);
    check("reset_state", 64'(dbg_state), 64'(ST_FETCH));
    st_rst = 1'b0;
    data_q.push_back(32'hAAAA_0001);
    data_q.push_back(32'hAAAA_0002);
    cyc(7);

    // stall while holding an instruction, then release
    st_stall = 1'b1;
    wait_full();
    cyc(5);
    st_stall = 1'b0;
    cyc(3);

    // redirect during WAIT; old response arrives later and is dropped
    wait_idle();
    st_lat = 3;
    wait_busy();
    st_redirect = 1'b1; st_target = 64'h1002;
    do_cycle();
    st_redirect = 1'b0;
    check("redirect_wait_addr", bus.imem_addr, 64'h1000);
    cyc(8);

    // redirect in the same cycle as the response
    wait_idle();
    st_lat = 0;
    wait_busy();
    st_redirect = 1'b1; st_target = 64'h2000;
    do_cycle();
    st_redirect = 1'b0;
    cyc(4);

    // redirect while FULL and stalled
    st_stall = 1'b1;
    wait_full();
    st_redirect = 1'b1; st_target = 64'h3000;
    do_cycle();
    st_redirect = 1'b0; st_stall = 1'b0;
    cyc(4);

    // request held off by ready=0, then reset while waiting
    wait_idle();
    st_ready = 1'b0;
    cyc(4);
    st_ready = 1'b1; st_lat = 3;
    wait_busy();
    st_rst = 1'b1;
    do_cycle();
    st_rst = 1'b0; st_lat = 0;
    cyc(4);

    // address wrap at the top of the space, redirect issued in FETCH
    wait_idle();
    st_redirect = 1'b1; st_target = 64'hFFFF_FFFF_FFFF_FFFC;
    do_cycle();
    st_redirect = 1'b0;
    wait_busy();
    check("wrap_addr", bus.imem_addr, 64'h0);
    cyc(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      st_stall    = ($urandom_range(0, 99) < 30);
      st_redirect = ($urandom_range(0, 99) < 6);
      st_target   = 64'($urandom_range(0, 32'hFFFF));
      st_ready    = ($urandom_range(0, 99) < 75);
      st_lat      = -1;
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
